data_mem_ctrl: RTL and testbench



---
 rtl/data_mem_ctrl_pkg.sv | 46 ++++
 rtl/data_mem_ctrl_if.sv | 52 +++++
 rtl/data_mem_ctrl_sram.sv | 42 ++++
 rtl/data_mem_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl_pkg
// Shared definitions for the data-memory controller of the 19-bit CPU:
//   - DATA_W        : machine word width (19 bits)
//   - BYTE/HALF_WORD/WORD/SIZE_RSVD : access-size encodings on byte_en
//   - WAIT_CNT_W    : width of the wait-state counter (covers 0..15)
//   - ctrl_state_e  : controller FSM states
//   - merge_subword : combines an old SRAM word with right-aligned store data
// ---------------------------------------------------------------------------
package data_mem_ctrl_pkg;

    localparam int DATA_W     = 19;
    localparam int WAIT_CNT_W = 4;

    // Access-size encodings; 2'b10 is reserved and always rejected.
    localparam logic [1:0] BYTE      = 2'b00;
    localparam logic [1:0] HALF_WORD = 2'b01;
    localparam logic [1:0] SIZE_RSVD = 2'b10;
    localparam logic [1:0] WORD      = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        MERGE,
        RESP,
        ERR
    } ctrl_state_e;

    // Sub-word stores only replace the low lanes; everything above the
    // written lane comes from the word already in the array.
    function automatic logic [DATA_W-1:0] merge_subword(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [1:0]        size
    );
        logic [DATA_W-1:0] merged;
        case (size)
            BYTE:      merged = {old_word[DATA_W-1:8],  new_word[7:0]};
            HALF_WORD: merged = {old_word[DATA_W-1:16], new_word[15:0]};
            default:   merged = new_word;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl_if
// Request/response bundle between the CPU data-memory stage (master) and
// the memory-side controller (slave).
//   data_mem_req_i      : request strobe
//   data_mem_addr_i     : word address
//   data_mem_byte_en_i  : access size (BYTE/HALF_WORD/WORD)
//   data_mem_wr_i       : 1 = store, 0 = load
//   data_mem_wr_data_i  : right-aligned store data
//   mem_rd_data_o       : raw read word
//   mem_ack_o           : one-cycle completion pulse
//   mem_busy_o          : controller not idle
//   mem_err_o           : error flag, valid with ack
// ---------------------------------------------------------------------------
interface data_mem_ctrl_if;
    import data_mem_ctrl_pkg::*;

    logic              data_mem_req_i;
    logic [DATA_W-1:0] data_mem_addr_i;
    logic [1:0]        data_mem_byte_en_i;
    logic              data_mem_wr_i;
    logic [DATA_W-1:0] data_mem_wr_data_i;
    logic [DATA_W-1:0] mem_rd_data_o;
    logic              mem_ack_o;
    logic              mem_busy_o;
    logic              mem_err_o;

    modport master (
        output data_mem_req_i,
        output data_mem_addr_i,
        output data_mem_byte_en_i,
        output data_mem_wr_i,
        output data_mem_wr_data_i,
        input  mem_rd_data_o,
        input  mem_ack_o,
        input  mem_busy_o,
        input  mem_err_o
    );

    modport slave (
        input  data_mem_req_i,
        input  data_mem_addr_i,
        input  data_mem_byte_en_i,
        input  data_mem_wr_i,
        input  data_mem_wr_data_i,
        output mem_rd_data_o,
        output mem_ack_o,
        output mem_busy_o,
        output mem_err_o
    );

endinterface

// File: rtl/data_mem_ctrl_sram.sv
// ---------------------------------------------------------------------------
// data_mem_sram
// Single-port synchronous word array, DEPTH x DATA_W. One read or one write
// per enabled cycle; read data is registered and holds until the next read.
// The array and the read register are deliberately not reset.
//   clk     : clock, rising edge
//   en_i    : access enable
//   we_i    : 1 = write, 0 = read (when enabled)
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data
// ---------------------------------------------------------------------------
module data_mem_sram
    import data_mem_ctrl_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// Memory-side controller behind the CPU data-memory stage. Accepts one
// request at a time, inserts WAIT_CYCLES wait states, then performs the
// access on the on-chip SRAM. Sub-word stores use read-modify-write.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : data_mem_ctrl_if slave modport (request in, response out)
// Parameters:
//   DEPTH       : number of words; addresses >= DEPTH are errors
//   WAIT_CYCLES : wait states before each array access (0..15)
// Latency from accept to ack: loads and WORD stores WAIT_CYCLES+2,
// sub-word stores WAIT_CYCLES+3, errors 1.
// ---------------------------------------------------------------------------
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    data_mem_ctrl_if.slave bus
);

    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ADDR_CMP_W = DATA_W + 1;

    // One extra bit keeps the range check correct even if DEPTH == 2**DATA_W.
    localparam logic [ADDR_CMP_W-1:0] DEPTH_LIM = ADDR_CMP_W'(DEPTH);

    // The counter loads WAIT_CYCLES-1 so that WAIT lasts exactly WAIT_CYCLES.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    ctrl_state_e           state_q,     state_d;
    logic [WAIT_CNT_W-1:0] cnt_q,       cnt_d;
    logic [AW-1:0]         addr_q,      addr_d;
    logic [1:0]            size_q,      size_d;
    logic                  wr_q,        wr_d;
    logic [DATA_W-1:0]     wr_data_q,   wr_data_d;
    logic [DATA_W-1:0]     rd_data_q,   rd_data_d;
    logic                  resp_rd_q,   resp_rd_d;
    logic                  ack_q,       ack_d;
    logic                  busy_q,      busy_d;
    logic                  err_q,       err_d;

    logic                  sram_en;
    logic                  sram_we;
    logic [DATA_W-1:0]     sram_wdata;
    logic [DATA_W-1:0]     sram_rdata;
    logic                  addr_bad;
    logic                  size_bad;

    data_mem_sram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk     (clk),
        .en_i    (sram_en),
        .we_i    (sram_we),
        .addr_i  (addr_q),
        .wdata_i (sram_wdata),
        .rdata_o (sram_rdata)
    );

    // Request validation: the full 19-bit address is range checked even
    // though only the low AW bits ever reach the array.
    always_comb begin
        addr_bad = ({1'b0, bus.data_mem_addr_i} >= DEPTH_LIM);
        size_bad = (bus.data_mem_byte_en_i == SIZE_RSVD);
    end

    // Next-state and next-output logic. SRAM strobes are decoded from the
    // current state so that an asynchronous reset during ACCESS or MERGE
    // drops the write before its clock edge can commit it. Response outputs
    // are computed from the next state so they come straight from flops.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        size_d     = size_q;
        wr_d       = wr_q;
        wr_data_d  = wr_data_q;
        rd_data_d  = rd_data_q;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_wdata = wr_data_q;

        case (state_q)
            IDLE: begin
                if (bus.data_mem_req_i) begin
                    addr_d    = bus.data_mem_addr_i[AW-1:0];
                    size_d    = bus.data_mem_byte_en_i;
                    wr_d      = bus.data_mem_wr_i;
                    wr_data_d = bus.data_mem_wr_data_i;
                    if (addr_bad || size_bad) begin
                        state_d = ERR;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: begin
                sram_en = 1'b1;
                if (wr_q && (size_q == WORD)) begin
                    sram_we = 1'b1;
                    state_d = RESP;
                end else if (wr_q) begin
                    state_d = MERGE;
                end else begin
                    state_d = RESP;
                end
            end
            MERGE: begin
                // The old word read in ACCESS is now on the SRAM output.
                sram_en    = 1'b1;
                sram_we    = 1'b1;
                sram_wdata = merge_subword(sram_rdata, wr_data_q, size_q);
                state_d    = RESP;
            end
            RESP: begin
                if (!wr_q) begin
                    rd_data_d = sram_rdata;
                end
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == ERR) begin
            rd_data_d = '0;
        end

        ack_d     = (state_d == RESP) || (state_d == ERR);
        err_d     = (state_d == ERR);
        busy_d    = (state_d != IDLE);
        resp_rd_d = (state_d == RESP) && !wr_q;
    end

    // Single register bank for the FSM, captured request and outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            size_q    <= WORD;
            wr_q      <= 1'b0;
            wr_data_q <= '0;
            rd_data_q <= '0;
            resp_rd_q <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wr_q      <= wr_d;
            wr_data_q <= wr_data_d;
            rd_data_q <= rd_data_d;
            resp_rd_q <= resp_rd_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    // During a load's RESP cycle the word is presented straight from the
    // SRAM read register so it lines up with ack; rd_data_q captures it at
    // the end of RESP and holds it afterwards. Both sources are flops.
    assign bus.mem_rd_data_o = resp_rd_q ? sram_rdata : rd_data_q;
    assign bus.mem_ack_o     = ack_q;
    assign bus.mem_busy_o    = busy_q;
    assign bus.mem_err_o     = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
// Self-checking bench for data_mem_ctrl (DEPTH=1024, WAIT_CYCLES=2).
// A reference memory model predicts every response; predictions are queued
// when a request is driven and popped when the controller acks.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;
    import data_mem_ctrl_pkg::*;

    localparam int DEPTH = 1024;
    localparam int W     = 2;
    localparam int BOUND = 40;

    typedef struct {
        logic        err;
        logic [18:0] data;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;

    int vectors     = 0;
    int miscompares = 0;

    logic [18:0] ref_mem [DEPTH];
    logic [18:0] ref_rd;
    exp_t        sb[$];

    always #5 clk = ~clk;

    data_mem_ctrl_if bus();

    data_mem_ctrl #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Reference lane merge, written with masks rather than slices.
    function automatic logic [18:0] ref_merge(input logic [1:0] size,
                                              input logic [18:0] old_w,
                                              input logic [18:0] new_w);
        if (size == 2'b00) return (old_w & 19'h7FF00) | (new_w & 19'h000FF);
        if (size == 2'b01) return (old_w & 19'h70000) | (new_w & 19'h0FFFF);
        return new_w;
    endfunction

    // Predict the response of one request and queue it.
    task automatic predict_push(input logic wr, input logic [1:0] size,
                                input logic [18:0] addr, input logic [18:0] wdata);
        exp_t e;
        if (int'(addr) >= DEPTH || size == 2'b10) begin
            e.err = 1'b1; e.data = 19'h0; e.lat = 1;
            ref_rd = 19'h0;
        end else if (!wr) begin
            e.err = 1'b0; e.data = ref_mem[addr[9:0]]; e.lat = W + 2;
            ref_rd = e.data;
        end else begin
            e.err = 1'b0; e.data = ref_rd;
            e.lat = (size == 2'b11) ? W + 2 : W + 3;
            ref_mem[addr[9:0]] = ref_merge(size, ref_mem[addr[9:0]], wdata);
        end
        sb.push_back(e);
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] size,
                             input logic [18:0] addr, input logic [18:0] wdata);
        bus.data_mem_wr_i      = wr;
        bus.data_mem_byte_en_i = size;
        bus.data_mem_addr_i    = addr;
        bus.data_mem_wr_data_i = wdata;
        bus.data_mem_req_i     = 1'b1;
    endtask

    // One complete transaction: drive, wait for ack, compare with the
    // scoreboard, then confirm the pulse ends and read data holds.
    task automatic run_txn(input logic wr, input logic [1:0] size,
                           input logic [18:0] addr, input logic [18:0] wdata,
                           input string name);
        exp_t e;
        int   lat;
        logic got;
        logic busy_low;
        predict_push(wr, size, addr, wdata);
        drive_req(wr, size, addr, wdata);
        lat = 0; got = 1'b0; busy_low = 1'b0;
        while (!got && lat < BOUND) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) bus.data_mem_req_i = 1'b0;
            if (bus.mem_ack_o === 1'b1) got = 1'b1;
            else if (bus.mem_busy_o !== 1'b1) busy_low = 1'b1;
        end
        e = sb.pop_front();
        vectors++;
        if (!got) begin
            miscompares++;
            $display("[TB] FAIL %s ack_timeout: no ack within %0d cycles, required ack", name, BOUND);
            return;
        end
        vectors++;
        if (lat !== e.lat) begin
            miscompares++;
            $display("[TB] FAIL %s latency: got %0d required %0d", name, lat, e.lat);
        end
        vectors++;
        if (bus.mem_err_o !== e.err) begin
            miscompares++;
            $display("[TB] FAIL %s err: got %b required %b", name, bus.mem_err_o, e.err);
        end
        vectors++;
        if (bus.mem_rd_data_o !== e.data) begin
            miscompares++;
            $display("[TB] FAIL %s rd_data: got %h required %h", name, bus.mem_rd_data_o, e.data);
        end
        vectors++;
        if (busy_low !== 1'b0 || bus.mem_busy_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s busy_during_op: got busy_low=%b busy_at_ack=%b required 0/1",
                     name, busy_low, bus.mem_busy_o);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.mem_ack_o !== 1'b0 || bus.mem_err_o !== 1'b0 || bus.mem_busy_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s after_ack: got ack=%b err=%b busy=%b required 0/0/0",
                     name, bus.mem_ack_o, bus.mem_err_o, bus.mem_busy_o);
        end
        vectors++;
        if (bus.mem_rd_data_o !== e.data) begin
            miscompares++;
            $display("[TB] FAIL %s rd_hold: got %h required %h", name, bus.mem_rd_data_o, e.data);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.data_mem_req_i = 1'b0;
        bus.data_mem_wr_i = 1'b0;
        bus.data_mem_byte_en_i = 2'b11;
        bus.data_mem_addr_i = '0;
        bus.data_mem_wr_data_i = '0;
        ref_rd = 19'h0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.mem_ack_o, bus.mem_busy_o, bus.mem_err_o} !== 3'b000 || bus.mem_rd_data_o !== 19'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got ack=%b busy=%b err=%b rd=%h required all 0",
                     bus.mem_ack_o, bus.mem_busy_o, bus.mem_err_o, bus.mem_rd_data_o);
        end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.mem_busy_o !== 1'b0 || bus.mem_ack_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: got busy=%b ack=%b required 0/0",
                     bus.mem_busy_o, bus.mem_ack_o);
        end
    endtask

    task automatic test_word_access();
        run_txn(1'b1, WORD, 19'd5, 19'h7FFFF, "word_store_5");
        run_txn(1'b0, WORD, 19'd5, 19'h00000, "word_load_5");
    endtask

    task automatic test_subword_store();
        run_txn(1'b1, WORD,      19'd5, 19'h12345, "init_5");
        run_txn(1'b1, BYTE,      19'd5, 19'h000A5, "byte_store_5");
        run_txn(1'b0, WORD,      19'd5, 19'h00000, "load_after_byte");
        run_txn(1'b1, WORD,      19'd9, 19'h7FFFF, "init_9");
        run_txn(1'b1, HALF_WORD, 19'd9, 19'h0BEEF, "half_store_9");
        run_txn(1'b0, WORD,      19'd9, 19'h00000, "load_after_half");
        run_txn(1'b1, BYTE,      19'd9, 19'h7FF3C, "byte_store_wide_data");
        run_txn(1'b0, BYTE,      19'd9, 19'h00000, "byte_load_raw_word");
    endtask

    task automatic test_errors();
        run_txn(1'b1, WORD, 19'd7,      19'h00777, "init_7");
        run_txn(1'b1, WORD, 19'd0,      19'h0ABCD, "init_0");
        run_txn(1'b0, WORD, 19'd7,      19'h00000, "load_7_pre");
        run_txn(1'b0, WORD, 19'd1024,   19'h00000, "err_addr_1024");
        run_txn(1'b0, WORD, 19'd7,      19'h00000, "load_7_refresh");
        run_txn(1'b0, 2'b10, 19'd7,     19'h00000, "err_size_rsvd");
        run_txn(1'b1, WORD, 19'd1024,   19'h11111, "err_store_1024");
        run_txn(1'b1, BYTE, 19'h40007,  19'h000EE, "err_store_high_bits");
        run_txn(1'b1, 2'b10, 19'd7,     19'h22222, "err_store_rsvd");
        run_txn(1'b0, WORD, 19'd1023,   19'h00000, "load_1023_setup");
        run_txn(1'b1, WORD, 19'd1023,   19'h3C3C3, "store_last_word");
        run_txn(1'b0, WORD, 19'd1023,   19'h00000, "load_last_word");
        run_txn(1'b0, WORD, 19'd7,      19'h00000, "load_7_unchanged");
        run_txn(1'b0, WORD, 19'd0,      19'h00000, "load_0_unchanged");
    endtask

    task automatic test_reset_mid_op();
        run_txn(1'b1, WORD, 19'd3, 19'h00111, "init_3");
        drive_req(1'b1, WORD, 19'd3, 19'h55555);
        @(posedge clk); #1;
        bus.data_mem_req_i = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (bus.mem_busy_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL busy_in_wait: got %b required 1", bus.mem_busy_o);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({bus.mem_ack_o, bus.mem_busy_o, bus.mem_err_o} !== 3'b000 || bus.mem_rd_data_o !== 19'h0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_clear: got ack=%b busy=%b err=%b rd=%h required all 0",
                     bus.mem_ack_o, bus.mem_busy_o, bus.mem_err_o, bus.mem_rd_data_o);
        end
        ref_rd = 19'h0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_txn(1'b0, WORD, 19'd3, 19'h00000, "load_3_after_reset");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        int   lat1;
        int   gap;
        logic got;
        run_txn(1'b1, WORD, 19'd1, 19'h01111, "init_1");
        run_txn(1'b1, WORD, 19'd2, 19'h02222, "init_2");
        predict_push(1'b0, WORD, 19'd1, 19'h0);
        predict_push(1'b0, WORD, 19'd2, 19'h0);
        drive_req(1'b0, WORD, 19'd1, 19'h0);
        cyc = 0; got = 1'b0;
        while (!got && cyc < BOUND) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.mem_ack_o === 1'b1) got = 1'b1;
        end
        lat1 = cyc;
        e = sb.pop_front();
        vectors++;
        if (!got || lat1 !== e.lat) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_ack: got ack=%b at %0d required ack at %0d", got, lat1, e.lat);
        end
        vectors++;
        if (bus.mem_rd_data_o !== e.data || bus.mem_err_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_data: got %h err=%b required %h err=0",
                     bus.mem_rd_data_o, bus.mem_err_o, e.data);
        end
        bus.data_mem_addr_i = 19'd2;
        gap = 0; got = 1'b0;
        while (!got && gap < BOUND) begin
            @(posedge clk); #1;
            gap++;
            if (bus.mem_ack_o === 1'b1) got = 1'b1;
        end
        bus.data_mem_req_i = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (!got || gap !== W + 3) begin
            miscompares++;
            $display("[TB] FAIL b2b_ack_spacing: got ack=%b spacing %0d required %0d", got, gap, W + 3);
        end
        vectors++;
        if (bus.mem_rd_data_o !== e.data || bus.mem_err_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_data: got %h err=%b required %h err=0",
                     bus.mem_rd_data_o, bus.mem_err_o, e.data);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.mem_busy_o !== 1'b0 || bus.mem_ack_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_idle_after: got busy=%b ack=%b required 0/0",
                     bus.mem_busy_o, bus.mem_ack_o);
        end
    endtask

    initial begin
        test_reset();
        test_word_access();
        test_subword_store();
        test_errors();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
